// File: rtl/adc_sample_averager.sv
// Block averager for sign-magnitude ADC samples: accumulates 2^LOG2_N samples and emits one
// truncated-toward-zero mean per block over a valid/ready handshake.
module adc_sample_averager #(
  parameter int unsigned LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [15:0]       sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [15:0]       adc_data,
  output logic              adc_valid,
  input  logic              adc_ready,
  output logic [LOG2_N-1:0] block_cnt
);

  localparam int unsigned AccW = 16 + LOG2_N;

  typedef enum logic [1:0] {StAccum, StDiv, StHold} state_e;

  state_e                  state_q, state_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [LOG2_N-1:0]       cnt_q, cnt_d;
  logic [15:0]             data_q, data_d;
  logic                    valid_q, valid_d;

  logic signed [AccW-1:0]  mag_ext;
  logic signed [AccW-1:0]  sample_val;
  logic signed [AccW-1:0]  abs_sum;
  logic [AccW-1:0]         mean_w;
  logic [14:0]             mean_mag;
  logic                    mean_sign;
  logic                    unused_mean;

  // Negative zero needs no special case: negating a zero magnitude yields zero.
  assign mag_ext    = {{(AccW-15){1'b0}}, sample_in[14:0]};
  assign sample_val = sample_in[15] ? -mag_ext : mag_ext;

  // |sum| / 2^LOG2_N always fits in 15 bits, so the upper bits are dropped.
  assign abs_sum     = acc_q[AccW-1] ? -acc_q : acc_q;
  assign mean_w      = $unsigned(abs_sum) >> LOG2_N;
  assign mean_mag    = mean_w[14:0];
  assign mean_sign   = acc_q[AccW-1] && (mean_mag != 15'd0);
  assign unused_mean = ^mean_w[AccW-1:15];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      state_d = StAccum;
      acc_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (sample_valid) begin
            acc_d = acc_q + sample_val;
            cnt_d = cnt_q + LOG2_N'(1);
            if (cnt_q == '1) state_d = StDiv;
          end
        end
        StDiv: begin
          data_d  = {mean_sign, mean_mag};
          valid_d = 1'b1;
          state_d = StHold;
        end
        StHold: begin
          if (adc_ready) begin
            valid_d = 1'b0;
            acc_d   = '0;
            state_d = StAccum;
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign sample_ready = (state_q == StAccum);
  assign adc_data     = data_q;
  assign adc_valid    = valid_q;
  assign block_cnt    = cnt_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed self-checking bench for adc_sample_averager with LOG2_N = 3 (8-sample blocks).
module tb_adc_sample_averager;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        adc_ready;
  logic [2:0]  block_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] vec [8];

  adc_sample_averager #(.LOG2_N(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .adc_ready    (adc_ready),
    .block_cnt    (block_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  // Sends vec[0..7] back-to-back with adc_ready high and checks the full output timing.
  task automatic run_block(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 8; i++) push(vec[i]);
    chk({tag, "_div_valid"}, 32'(adc_valid), 32'd0);
    chk({tag, "_div_ready"}, 32'(sample_ready), 32'd0);
    chk({tag, "_div_cnt"}, 32'(block_cnt), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(adc_valid), 32'd1);
    chk({tag, "_data"}, 32'(adc_data), 32'(exp));
    step();
    chk({tag, "_xfer_valid"}, 32'(adc_valid), 32'd0);
    chk({tag, "_xfer_ready"}, 32'(sample_ready), 32'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    clear        = 1'b0;
    sample_in    = 16'h0000;
    sample_valid = 1'b0;
    adc_ready    = 1'b1;
    #12;
    rst_n = 1'b1;
    step();

    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk("rst_valid", 32'(adc_valid), 32'd0);
    chk("rst_data", 32'(adc_data), 32'h0000);
    chk("rst_cnt", 32'(block_cnt), 32'd0);

    // Uniform block, with a mid-block count check.
    for (int i = 0; i < 3; i++) push(16'h0010);
    chk("uni_cnt3", 32'(block_cnt), 32'd3);
    for (int i = 3; i < 8; i++) push(16'h0010);
    chk("uni_div_valid", 32'(adc_valid), 32'd0);
    step();
    chk("uni_valid", 32'(adc_valid), 32'd1);
    chk("uni_data", 32'(adc_data), 32'h0010);
    step();
    chk("uni_xfer_valid", 32'(adc_valid), 32'd0);
    chk("uni_xfer_ready", 32'(sample_ready), 32'd1);

    vec = '{16'h0064, 16'h8032, 16'h0064, 16'h8032, 16'h0064, 16'h8032, 16'h0064, 16'h8032};
    run_block("mixed", 16'h0019);
    vec = '{default: 16'h7FFF};
    run_block("maxpos", 16'h7FFF);
    vec = '{default: 16'hFFFF};
    run_block("maxneg", 16'hFFFF);
    vec = '{16'h8009, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_block("trunc9", 16'h8001);
    vec = '{16'h8007, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_block("trunc7", 16'h0000);
    vec = '{default: 16'h8000};
    run_block("negzero", 16'h0000);

    // Backpressure: upstream keeps offering a sample throughout the stall.
    adc_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h0030);
    sample_in    = 16'h0040;
    sample_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(adc_valid), 32'd1);
      chk("bp_data", 32'(adc_data), 32'h0030);
      chk("bp_ready", 32'(sample_ready), 32'd0);
      chk("bp_cnt", 32'(block_cnt), 32'd0);
      step();
    end
    adc_ready    = 1'b1;
    sample_valid = 1'b0;
    step();
    chk("bp_xfer_valid", 32'(adc_valid), 32'd0);
    chk("bp_xfer_ready", 32'(sample_ready), 32'd1);
    chk("bp_xfer_cnt", 32'(block_cnt), 32'd0);

    // clear mid-block discards the partial sum and the concurrent sample.
    for (int i = 0; i < 5; i++) push(16'h0100);
    chk("clr_cnt5", 32'(block_cnt), 32'd5);
    clear        = 1'b1;
    sample_in    = 16'h7FFF;
    sample_valid = 1'b1;
    step();
    clear        = 1'b0;
    sample_valid = 1'b0;
    chk("clr_cnt0", 32'(block_cnt), 32'd0);
    chk("clr_ready", 32'(sample_ready), 32'd1);
    vec = '{default: 16'h0020};
    run_block("after_clr", 16'h0020);

    // clear in HOLD drops the pending output.
    adc_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h0050);
    step();
    chk("hold_valid", 32'(adc_valid), 32'd1);
    chk("hold_data", 32'(adc_data), 32'h0050);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("hold_clr_valid", 32'(adc_valid), 32'd0);
    chk("hold_clr_data", 32'(adc_data), 32'h0050);
    chk("hold_clr_ready", 32'(sample_ready), 32'd1);
    adc_ready = 1'b1;

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) push(16'h1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(sample_ready), 32'd1);
    chk("arst_cnt", 32'(block_cnt), 32'd0);
    chk("arst_valid", 32'(adc_valid), 32'd0);
    chk("arst_data", 32'(adc_data), 32'h0000);
    #2;
    rst_n = 1'b1;
    step();
    vec = '{default: 16'h8004};
    run_block("post_rst", 16'h8004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
